fifo_serializer: RTL and testbench
==================================

FIFO_SERIALIZER -- requirements
Module: fifo_serializer

Interface
REQ-001 SHALL have parameter BEAT_W, default 16, output beat width; legal values are 8, 16 and 32.
REQ-002 SHALL have parameter WAIT_MAX, default 4, the maximum number of cycles to wait for FIFO data after a request.
REQ-003 SHALL have port clock_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port en_i, input, 1 bit: when 1, the block may start new FIFO requests.
REQ-006 SHALL have port fifo_req_o, output, 1 bit: one-cycle pop request to the upstream FIFO.
REQ-007 SHALL have port fifo_data_i, input, 64 bits: word from the FIFO.
REQ-008 SHALL have port fifo_v_i, input, 1 bit: fifo_data_i is valid this cycle.
REQ-009 SHALL have port beat_o, output, BEAT_W bits: serialized beat.
REQ-010 SHALL have port beat_v_o, output, 1 bit: beat_o is valid.
REQ-011 SHALL have port beat_rdy_i, input, 1 bit: downstream accepts; a beat transfers when beat_v_o and beat_rdy_i are both 1.
REQ-012 SHALL have port beat_last_o, output, 1 bit: the current beat is the final beat of a word.
REQ-013 SHALL have port timeout_o, output, 1 bit: one-cycle pulse when a request times out.
REQ-014 SHALL have port word_cnt_o, output, 16 bits: count of fully sent words; wraps from 0xFFFF to 0.

Function
REQ-015 SHALL implement FSM states IDLE, REQ, WAIT and SEND; NB = 64/BEAT_W beats per word.
REQ-016 IDLE SHALL go to REQ when en_i=1 and SHALL otherwise stay in IDLE.
REQ-017 REQ SHALL assert fifo_req_o for exactly one cycle, then go to WAIT with the wait counter cleared.
REQ-018 WAIT SHALL, on fifo_v_i=1, capture fifo_data_i into a 64-bit shift register, clear the beat index, and go to SEND.
REQ-019 WAIT SHALL, after WAIT_MAX cycles with fifo_v_i=0, pulse timeout_o for 1 cycle and go to IDLE.
REQ-020 fifo_v_i SHALL be ignored outside WAIT, with no capture and no state change.
REQ-021 SEND SHALL hold beat_v_o=1 and output beats LSB first: beat k = word[k*BEAT_W +: BEAT_W].
REQ-022 While beat_v_o=1 and beat_rdy_i=0, beat_o, beat_last_o and beat_v_o SHALL remain stable.
REQ-023 beat_last_o SHALL be 1 only when the beat index equals NB-1.
REQ-024 On transfer of the last beat, word_cnt_o SHALL increment by 1.
REQ-025 On transfer of the last beat, the next state SHALL be REQ if en_i=1 (back-to-back operation) or IDLE if en_i=0.
REQ-026 Deasserting en_i during REQ, WAIT or SEND SHALL NOT abort the current word.
REQ-027 Latency SHALL be: fifo_req_o at cycle t, fifo_v_i at t+1, first beat_v_o at t+2.
REQ-028 Minimum word period SHALL be NB+2 cycles with beat_rdy_i held at 1.

Reset
REQ-029 While rst_i=1, the block SHALL be in state IDLE and SHALL drive fifo_req_o=0, beat_v_o=0, beat_o=0, beat_last_o=0, timeout_o=0 and word_cnt_o=0, and SHALL clear the shift register and counters.
REQ-030 Reset asserted mid-word SHALL discard the word without a count increment; the block SHALL resume from IDLE on the first edge after release.

Configuration
REQ-031 SHALL support macro FIFO_SERIALIZER_PARITY_EN.
REQ-032 When FIFO_SERIALIZER_PARITY_EN is defined, the block SHALL add output beat_par_o, 1 bit, the even parity (XOR) of beat_o, valid with beat_v_o and 0 in reset.
REQ-033 When FIFO_SERIALIZER_PARITY_EN is not defined, beat_par_o and its logic SHALL be absent.

Structure
REQ-034 Package fifo_ser_pkg SHALL hold the state enum, the FIFO word width constant (64) and the default BEAT_W.
REQ-035 SHALL be a single module with no sub-module; parity SHALL be inline logic.

Verification
REQ-036 Word 0x0123_4567_89AB_CDEF, BEAT_W=16, beat_rdy_i=1: beats CDEF, 89AB, 4567, 0123; beat_last_o on the 4th; word_cnt_o=1.
REQ-037 beat_rdy_i=0 for 3 cycles on beat 2: beat_o stays 89AB and beat_v_o stays 1 throughout; sequence then completes.
REQ-038 fifo_v_i never asserts after a request: timeout_o pulses exactly WAIT_MAX+1 cycles after fifo_req_o, state returns to IDLE, word_cnt_o is unchanged.
REQ-039 rst_i asserted after beat 1 of a word: all outputs go to 0 immediately; after release, the next word serializes correctly from beat 0.
REQ-040 en_i=1 held, two words sent: fifo_req_o fires the cycle after the first word's last beat; word_cnt_o=2 after 12 cycles of back-to-back operation.
REQ-041 With FIFO_SERIALIZER_PARITY_EN defined, beat 0x0003 gives beat_par_o=0 and beat 0x0007 gives beat_par_o=1.

Source files
------------

// File: rtl/fifo_serializer_pkg.sv
`default_nettype none
// ============================================================================
// fifo_ser_pkg : state encoding and widths for fifo_serializer      rev 1.0
// ============================================================================
package fifo_ser_pkg;

  localparam int c_FIFO_W         = 64;
  localparam int c_BEAT_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_SEND = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/fifo_serializer_if.sv
`default_nettype none
// ============================================================================
// fifo_serializer_if : FIFO pop side and beat stream side          rev 1.0
// beat_par_o exists only when FIFO_SERIALIZER_PARITY_EN is defined.
// ============================================================================
interface fifo_serializer_if
  import fifo_ser_pkg::*;
#(
  parameter int BEAT_W = c_BEAT_W_DEFAULT
);

  logic                fifo_req_o;
  logic [c_FIFO_W-1:0] fifo_data_i;
  logic                fifo_v_i;
  logic [BEAT_W-1:0]   beat_o;
  logic                beat_v_o;
  logic                beat_rdy_i;
  logic                beat_last_o;
`ifdef FIFO_SERIALIZER_PARITY_EN
  logic                beat_par_o;
`endif

  modport master (
    output fifo_req_o,
    input  fifo_data_i,
    input  fifo_v_i,
    output beat_o,
    output beat_v_o,
    input  beat_rdy_i,
`ifdef FIFO_SERIALIZER_PARITY_EN
    output beat_par_o,
`endif
    output beat_last_o
  );

  modport slave (
    input  fifo_req_o,
    output fifo_data_i,
    output fifo_v_i,
    input  beat_o,
    input  beat_v_o,
    output beat_rdy_i,
`ifdef FIFO_SERIALIZER_PARITY_EN
    input  beat_par_o,
`endif
    input  beat_last_o
  );

endinterface
`default_nettype wire

// File: rtl/fifo_serializer.sv
`default_nettype none
// ============================================================================
// fifo_serializer : pops 64-bit FIFO words, emits them LSB-first as beats
// Optional beat parity via FIFO_SERIALIZER_PARITY_EN.               rev 1.0
// ============================================================================
module fifo_serializer
  import fifo_ser_pkg::*;
#(
  parameter int BEAT_W   = c_BEAT_W_DEFAULT,
  parameter int WAIT_MAX = 4
) (
  input  wire                clock_i,
  input  wire                rst_i,
  input  wire                en_i,
  output logic               timeout_o,
  output logic [15:0]        word_cnt_o,
  fifo_serializer_if.master  bus
);

  localparam int NB     = c_FIFO_W / BEAT_W;
  localparam int IDX_W  = $clog2(NB);
  localparam int WCNT_W = $clog2(WAIT_MAX + 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_FIFO_W-1:0] r_shift;
  logic [IDX_W-1:0]    r_idx;
  logic [WCNT_W-1:0]   r_wait_cnt;
  logic [15:0]         r_word_cnt;
  logic                r_timeout;

  logic                w_beat_v;
  logic                w_xfer;
  logic                w_last;
  logic                w_wait_done;
  logic [BEAT_W-1:0]   w_beat;

  assign w_beat_v    = (r_state == S_SEND);
  assign w_xfer      = w_beat_v && bus.beat_rdy_i;
  assign w_last      = (r_idx == IDX_W'(NB - 1));
  assign w_wait_done = (r_wait_cnt == WCNT_W'(WAIT_MAX - 1));
  assign w_beat      = w_beat_v ? r_shift[BEAT_W-1:0] : '0;

  always_ff @(posedge clock_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (en_i) w_state_nxt = S_REQ;
      S_REQ:  w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (bus.fifo_v_i) begin
          w_state_nxt = S_SEND;
        end else if (w_wait_done) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SEND: begin
        // en_i only matters once the word is finished, so a drop never aborts it
        if (w_xfer && w_last) begin
          w_state_nxt = en_i ? S_REQ : S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or posedge rst_i) begin
    if (rst_i) begin
      r_shift    <= '0;
      r_idx      <= '0;
      r_wait_cnt <= '0;
      r_word_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        S_REQ: r_wait_cnt <= '0;
        S_WAIT: begin
          if (bus.fifo_v_i) begin
            r_shift <= bus.fifo_data_i;
            r_idx   <= '0;
          end else if (w_wait_done) begin
            r_timeout <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + WCNT_W'(1);
          end
        end
        S_SEND: begin
          if (w_xfer) begin
            r_shift <= r_shift >> BEAT_W;
            r_idx   <= r_idx + IDX_W'(1);
            if (w_last) r_word_cnt <= r_word_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.fifo_req_o  = (r_state == S_REQ);
  assign bus.beat_v_o    = w_beat_v;
  assign bus.beat_o      = w_beat;
  assign bus.beat_last_o = w_beat_v && w_last;
  assign timeout_o       = r_timeout;
  assign word_cnt_o      = r_word_cnt;

`ifdef FIFO_SERIALIZER_PARITY_EN
  assign bus.beat_par_o = ^w_beat;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_serializer.sv
`default_nettype none
// ============================================================================
// tb_fifo_serializer : directed self-checking bench, BEAT_W=16, WAIT_MAX=4
// ============================================================================
module tb_fifo_serializer;

  logic        clk;
  logic        rst;
  logic        en;
  logic        timeout;
  logic [15:0] word_cnt;

  int checks;
  int errors;

  logic        resp_en;
  logic        force_v;
  logic        req_last;
  logic [63:0] words [8];
  int          widx;

  fifo_serializer_if #(.BEAT_W(16)) bus_if ();

  fifo_serializer #(.BEAT_W(16), .WAIT_MAX(4)) dut (
    .clock_i    (clk),
    .rst_i      (rst),
    .en_i       (en),
    .timeout_o  (timeout),
    .word_cnt_o (word_cnt),
    .bus        (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to the next falling edge; the upstream FIFO answers a request one cycle later.
  task automatic tick();
    @(negedge clk);
    bus_if.fifo_v_i = force_v || (resp_en && req_last);
    if (resp_en && req_last) begin
      bus_if.fifo_data_i = words[widx];
      widx++;
    end else if (force_v) begin
      bus_if.fifo_data_i = 64'hDEAD_BEEF_DEAD_BEEF;
    end
    req_last = bus_if.fifo_req_o;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; force_v = 1'b1;
    repeat (3) tick();
    checks++; if (bus_if.fifo_req_o !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", bus_if.fifo_req_o); end
    checks++; if (bus_if.beat_v_o !== 1'b0) begin errors++; $display("FAIL rst_beat_v got %b want 0", bus_if.beat_v_o); end
    checks++; if (bus_if.beat_o !== 16'h0) begin errors++; $display("FAIL rst_beat got %h want 0000", bus_if.beat_o); end
    checks++; if (bus_if.beat_last_o !== 1'b0) begin errors++; $display("FAIL rst_last got %b want 0", bus_if.beat_last_o); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout got %b want 0", timeout); end
    checks++; if (word_cnt !== 16'd0) begin errors++; $display("FAIL rst_cnt got %0d want 0", word_cnt); end
    rst = 1'b0; en = 1'b0; force_v = 1'b0;
    tick();
    checks++; if (bus_if.fifo_req_o !== 1'b0 || bus_if.beat_v_o !== 1'b0) begin
      errors++; $display("FAIL idle_hold got req=%b v=%b want 0 0", bus_if.fifo_req_o, bus_if.beat_v_o);
    end
  endtask

  task automatic test_basic();
    logic [15:0] eb [4];
    eb[0] = 16'hCDEF; eb[1] = 16'h89AB; eb[2] = 16'h4567; eb[3] = 16'h0123;
    words[0] = 64'h0123_4567_89AB_CDEF; widx = 0; resp_en = 1'b1;
    en = 1'b1;
    tick();
    checks++; if (bus_if.fifo_req_o !== 1'b1) begin errors++; $display("FAIL basic_req got %b want 1", bus_if.fifo_req_o); end
    en = 1'b0;
    tick();
    checks++; if (bus_if.fifo_req_o !== 1'b0 || bus_if.beat_v_o !== 1'b0) begin
      errors++; $display("FAIL basic_wait got req=%b v=%b want 0 0", bus_if.fifo_req_o, bus_if.beat_v_o);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (bus_if.beat_v_o !== 1'b1 || bus_if.beat_o !== eb[k] || bus_if.beat_last_o !== (k == 3)) begin
        errors++; $display("FAIL basic_beat%0d got v=%b d=%h l=%b want 1 %h %b", k, bus_if.beat_v_o, bus_if.beat_o, bus_if.beat_last_o, eb[k], (k == 3));
      end
    end
    tick();
    checks++; if (bus_if.beat_v_o !== 1'b0 || word_cnt !== 16'd1 || bus_if.fifo_req_o !== 1'b0) begin
      errors++; $display("FAIL basic_done got v=%b cnt=%0d req=%b want 0 1 0", bus_if.beat_v_o, word_cnt, bus_if.fifo_req_o);
    end
  endtask

  task automatic test_backpressure();
    words[0] = 64'h0123_4567_89AB_CDEF; widx = 0; resp_en = 1'b1;
    en = 1'b1; tick(); en = 1'b0; tick(); tick();
    checks++; if (bus_if.beat_o !== 16'hCDEF) begin errors++; $display("FAIL bp_beat0 got %h want cdef", bus_if.beat_o); end
    tick();
    bus_if.beat_rdy_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus_if.beat_v_o !== 1'b1 || bus_if.beat_o !== 16'h89AB || bus_if.beat_last_o !== 1'b0) begin
        errors++; $display("FAIL bp_stall%0d got v=%b d=%h l=%b want 1 89ab 0", i, bus_if.beat_v_o, bus_if.beat_o, bus_if.beat_last_o);
      end
    end
    bus_if.beat_rdy_i = 1'b1;
    tick();
    checks++; if (bus_if.beat_o !== 16'h4567) begin errors++; $display("FAIL bp_beat2 got %h want 4567", bus_if.beat_o); end
    tick();
    checks++; if (bus_if.beat_o !== 16'h0123 || bus_if.beat_last_o !== 1'b1) begin
      errors++; $display("FAIL bp_beat3 got d=%h l=%b want 0123 1", bus_if.beat_o, bus_if.beat_last_o);
    end
    tick();
    checks++; if (word_cnt !== 16'd2 || bus_if.beat_v_o !== 1'b0) begin
      errors++; $display("FAIL bp_done got cnt=%0d v=%b want 2 0", word_cnt, bus_if.beat_v_o);
    end
  endtask

  task automatic test_timeout();
    int to_first;
    int to_count;
    resp_en = 1'b0; to_first = -1; to_count = 0;
    en = 1'b1; tick();
    checks++; if (bus_if.fifo_req_o !== 1'b1) begin errors++; $display("FAIL to_req got %b want 1", bus_if.fifo_req_o); end
    en = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (timeout === 1'b1) begin
        to_count++;
        if (to_first < 0) to_first = i;
      end
    end
    checks++; if (to_first != 5) begin errors++; $display("FAIL to_when got %0d want 5", to_first); end
    checks++; if (to_count != 1) begin errors++; $display("FAIL to_width got %0d want 1", to_count); end
    checks++; if (word_cnt !== 16'd2 || bus_if.beat_v_o !== 1'b0 || bus_if.fifo_req_o !== 1'b0) begin
      errors++; $display("FAIL to_idle got cnt=%0d v=%b req=%b want 2 0 0", word_cnt, bus_if.beat_v_o, bus_if.fifo_req_o);
    end
    force_v = 1'b1;
    repeat (3) tick();
    checks++; if (bus_if.beat_v_o !== 1'b0 || bus_if.fifo_req_o !== 1'b0) begin
      errors++; $display("FAIL ignore_v got v=%b req=%b want 0 0", bus_if.beat_v_o, bus_if.fifo_req_o);
    end
    force_v = 1'b0;
  endtask

  task automatic test_reset_midword();
    logic [15:0] eb [4];
    eb[0] = 16'hCDEF; eb[1] = 16'h89AB; eb[2] = 16'h4567; eb[3] = 16'h0123;
    words[0] = 64'h1111_2222_3333_4444; words[1] = 64'h0123_4567_89AB_CDEF;
    widx = 0; resp_en = 1'b1;
    en = 1'b1; tick(); en = 1'b0; tick(); tick();
    checks++; if (bus_if.beat_o !== 16'h4444) begin errors++; $display("FAIL rm_beat0 got %h want 4444", bus_if.beat_o); end
    tick();
    checks++; if (bus_if.beat_o !== 16'h3333) begin errors++; $display("FAIL rm_beat1 got %h want 3333", bus_if.beat_o); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus_if.beat_v_o !== 1'b0 || bus_if.beat_o !== 16'h0 || bus_if.beat_last_o !== 1'b0 ||
                  word_cnt !== 16'd0 || bus_if.fifo_req_o !== 1'b0 || timeout !== 1'b0) begin
      errors++; $display("FAIL rm_async got v=%b d=%h l=%b cnt=%0d req=%b to=%b want all 0",
                         bus_if.beat_v_o, bus_if.beat_o, bus_if.beat_last_o, word_cnt, bus_if.fifo_req_o, timeout);
    end
    tick();
    rst = 1'b0; en = 1'b1;
    tick();
    checks++; if (bus_if.fifo_req_o !== 1'b1) begin errors++; $display("FAIL rm_resume got %b want 1", bus_if.fifo_req_o); end
    en = 1'b0; tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (bus_if.beat_v_o !== 1'b1 || bus_if.beat_o !== eb[k]) begin
        errors++; $display("FAIL rm_beat_after%0d got v=%b d=%h want 1 %h", k, bus_if.beat_v_o, bus_if.beat_o, eb[k]);
      end
    end
    tick();
    checks++; if (word_cnt !== 16'd1) begin errors++; $display("FAIL rm_cnt got %0d want 1", word_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] eb [14];
    logic        exp_req, exp_v, exp_last;
    for (int i = 0; i < 14; i++) eb[i] = 16'h0;
    eb[3] = 16'hDDDD; eb[4] = 16'hCCCC; eb[5] = 16'hBBBB; eb[6] = 16'hAAAA;
    eb[9] = 16'hCDEF; eb[10] = 16'h89AB; eb[11] = 16'h4567; eb[12] = 16'h0123;
    words[0] = 64'hAAAA_BBBB_CCCC_DDDD; words[1] = 64'h0123_4567_89AB_CDEF;
    widx = 0; resp_en = 1'b1;
    rst = 1'b1; tick(); tick();
    rst = 1'b0; en = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      tick();
      exp_req  = (i == 1) || (i == 7);
      exp_v    = ((i >= 3) && (i <= 6)) || ((i >= 9) && (i <= 12));
      exp_last = (i == 6) || (i == 12);
      checks++; if (bus_if.fifo_req_o !== exp_req || bus_if.beat_v_o !== exp_v || bus_if.beat_last_o !== exp_last) begin
        errors++; $display("FAIL b2b_ctl_c%0d got req=%b v=%b l=%b want %b %b %b", i, bus_if.fifo_req_o,
                           bus_if.beat_v_o, bus_if.beat_last_o, exp_req, exp_v, exp_last);
      end
      if (exp_v) begin
        checks++; if (bus_if.beat_o !== eb[i]) begin errors++; $display("FAIL b2b_beat_c%0d got %h want %h", i, bus_if.beat_o, eb[i]); end
      end
      if (i == 12) begin
        checks++; if (word_cnt !== 16'd1) begin errors++; $display("FAIL b2b_cnt12 got %0d want 1", word_cnt); end
        en = 1'b0;
      end
    end
    checks++; if (word_cnt !== 16'd2) begin errors++; $display("FAIL b2b_cnt13 got %0d want 2", word_cnt); end
  endtask

`ifdef FIFO_SERIALIZER_PARITY_EN
  task automatic test_parity();
    words[0] = 64'h0000_0000_0007_0003; widx = 0; resp_en = 1'b1;
    en = 1'b1; tick(); en = 1'b0; tick(); tick();
    checks++; if (bus_if.beat_o !== 16'h0003 || bus_if.beat_par_o !== 1'b0) begin
      errors++; $display("FAIL par_0003 got d=%h p=%b want 0003 0", bus_if.beat_o, bus_if.beat_par_o);
    end
    tick();
    checks++; if (bus_if.beat_o !== 16'h0007 || bus_if.beat_par_o !== 1'b1) begin
      errors++; $display("FAIL par_0007 got d=%h p=%b want 0007 1", bus_if.beat_o, bus_if.beat_par_o);
    end
    repeat (3) tick();
    checks++; if (bus_if.beat_par_o !== 1'b0) begin errors++; $display("FAIL par_idle got %b want 0", bus_if.beat_par_o); end
  endtask
`endif

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; en = 1'b0; resp_en = 1'b0; force_v = 1'b0; req_last = 1'b0; widx = 0;
    for (int i = 0; i < 8; i++) words[i] = 64'h0;
    bus_if.fifo_v_i    = 1'b0;
    bus_if.fifo_data_i = 64'h0;
    bus_if.beat_rdy_i  = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_timeout();
    test_reset_midword();
    test_back_to_back();
`ifdef FIFO_SERIALIZER_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
